// File: rtl/spectrum_pkg.sv
// spectrum_pkg: default sizing constants and the
// level saturation helper for the spectrum bin capture.
package spectrum_pkg;

  localparam int WIDTH_DEF      = 12;
  localparam int BINS_DEF       = 8;
  localparam int LEVEL_W_DEF    = 8;
  localparam int SHIFT_DEF      = 6;
  localparam int DECAY_STEP_DEF = 16;

  // Clamp v to the largest value representable in lw bits.
  function automatic logic [31:0] sat_level(
    input logic [63:0] v,
    input int unsigned lw
  );
    logic [63:0] maxv;
    maxv = (64'd1 << lw) - 64'd1;
    if (v > maxv) sat_level = maxv[31:0];
    else          sat_level = v[31:0];
  endfunction

endpackage

// File: rtl/spectrum_bins_cplx_mag_sq.sv
// cplx_mag_sq: two-stage |z|^2 >> SHIFT pipeline with
// saturation, carrying a valid tag and a side tag along.
module cplx_mag_sq
  import spectrum_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int LEVEL_W = LEVEL_W_DEF,
  parameter int SHIFT   = SHIFT_DEF,
  parameter int TAG_W   = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  input  logic [TAG_W-1:0]        in_tag,
  input  logic signed [WIDTH-1:0] in_real,
  input  logic signed [WIDTH-1:0] in_imag,
  output logic                    out_valid,
  output logic [TAG_W-1:0]        out_tag,
  output logic [LEVEL_W-1:0]      out_mag
);

  localparam int PW = 2 * WIDTH;
  localparam int SW = 2 * WIDTH + 1;

  logic signed [PW-1:0] sx_re;
  logic signed [PW-1:0] sx_im;
  logic signed [PW-1:0] p_re;
  logic signed [PW-1:0] p_im;

  logic [PW-1:0]    sq_re_d, sq_re_q;
  logic [PW-1:0]    sq_im_d, sq_im_q;
  logic             s1_valid_d, s1_valid_q;
  logic [TAG_W-1:0] s1_tag_d, s1_tag_q;

  logic [SW-1:0]      sum;
  logic [SW-1:0]      shifted;
  logic [63:0]        wide;
  logic [31:0]        sat;
  logic [LEVEL_W-1:0] mag_d, mag_q;
  logic               s2_valid_d, s2_valid_q;
  logic [TAG_W-1:0]   s2_tag_d, s2_tag_q;

  // Stage 1: squares of the sign-extended parts.
  always_comb begin
    sx_re      = {{WIDTH{in_real[WIDTH-1]}}, in_real};
    sx_im      = {{WIDTH{in_imag[WIDTH-1]}}, in_imag};
    p_re       = sx_re * sx_re;
    p_im       = sx_im * sx_im;
    sq_re_d    = p_re;
    sq_im_d    = p_im;
    s1_valid_d = in_valid;
    s1_tag_d   = in_tag;
  end

  // Stage 2: unsigned sum, shift, saturate.
  always_comb begin
    sum             = {1'b0, sq_re_q} + {1'b0, sq_im_q};
    shifted         = sum >> SHIFT;
    wide            = '0;
    wide[SW-1:0]    = shifted;
    sat             = sat_level(wide, LEVEL_W);
    mag_d           = sat[LEVEL_W-1:0];
    s2_valid_d      = s1_valid_q;
    s2_tag_d        = s1_tag_q;
  end

  // Pipeline registers; valid tags cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sq_re_q    <= '0;
      sq_im_q    <= '0;
      s1_valid_q <= 1'b0;
      s1_tag_q   <= '0;
      mag_q      <= '0;
      s2_valid_q <= 1'b0;
      s2_tag_q   <= '0;
    end else begin
      sq_re_q    <= sq_re_d;
      sq_im_q    <= sq_im_d;
      s1_valid_q <= s1_valid_d;
      s1_tag_q   <= s1_tag_d;
      mag_q      <= mag_d;
      s2_valid_q <= s2_valid_d;
      s2_tag_q   <= s2_tag_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_tag   = s2_tag_q;
  assign out_mag   = mag_q;

endmodule

// File: rtl/spectrum_bins.sv
// spectrum_bins: captures the first BINS FFT magnitudes
// per frame; SPECTRUM_PEAK_HOLD_EN adds decaying peak hold.
module spectrum_bins
  import spectrum_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int BINS       = BINS_DEF,
  parameter int LEVEL_W    = LEVEL_W_DEF,
  parameter int SHIFT      = SHIFT_DEF,
  parameter int DECAY_STEP = DECAY_STEP_DEF
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  input  logic                      in_sync,
  input  logic signed [WIDTH-1:0]   in_real,
  input  logic signed [WIDTH-1:0]   in_imag,
  output logic [BINS*LEVEL_W-1:0]   levels,
  output logic                      frame_valid
);

  // Index value BINS doubles as "unsynced" and "past the end".
  localparam int IDX_W = $clog2(BINS + 1);
  localparam logic [IDX_W-1:0] IDX_SAT  = IDX_W'(BINS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BINS - 1);

  logic [IDX_W-1:0] idx_d, idx_q;
  logic [IDX_W-1:0] cur_idx;
  logic             keep;

  logic               mag_valid;
  logic [IDX_W-1:0]   mag_tag;
  logic [LEVEL_W-1:0] mag;

  logic [BINS-1:0][LEVEL_W-1:0] bank_d, bank_q;
  logic [BINS-1:0][LEVEL_W-1:0] levels_d, levels_q;
  logic                         commit_d, commit_q;
  logic                         frame_valid_d, frame_valid_q;

`ifdef SPECTRUM_PEAK_HOLD_EN
  localparam logic [31:0] DSTEP_W =
    sat_level(64'(DECAY_STEP), LEVEL_W);
  localparam logic [LEVEL_W-1:0] DSTEP = DSTEP_W[LEVEL_W-1:0];

  // Keep the higher of the new value and the decayed old one.
  function automatic logic [LEVEL_W-1:0] peak_next(
    input logic [LEVEL_W-1:0] old_v,
    input logic [LEVEL_W-1:0] new_v
  );
    logic [LEVEL_W-1:0] dec;
    if (new_v >= old_v) return new_v;
    dec = (old_v > DSTEP) ? old_v - DSTEP : '0;
    return (new_v > dec) ? new_v : dec;
  endfunction
`endif

  // Bin index of the incoming sample; saturates at BINS.
  always_comb begin
    cur_idx = IDX_SAT;
    if (in_sync)
      cur_idx = '0;
    else if (idx_q != IDX_SAT)
      cur_idx = idx_q + IDX_W'(1);
    idx_d = in_valid ? cur_idx : idx_q;
    keep  = in_valid && (cur_idx != IDX_SAT);
  end

  cplx_mag_sq #(
    .WIDTH   (WIDTH),
    .LEVEL_W (LEVEL_W),
    .SHIFT   (SHIFT),
    .TAG_W   (IDX_W)
  ) u_mag (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (keep),
    .in_tag    (cur_idx),
    .in_real   (in_real),
    .in_imag   (in_imag),
    .out_valid (mag_valid),
    .out_tag   (mag_tag),
    .out_mag   (mag)
  );

  // Working bank write; the last bin arms a commit.
  always_comb begin
    bank_d   = bank_q;
    commit_d = 1'b0;
    if (mag_valid) begin
      for (int k = 0; k < BINS; k++)
        if (mag_tag == IDX_W'(k)) bank_d[k] = mag;
      commit_d = (mag_tag == IDX_LAST);
    end
  end

  // Atomic transfer of the whole bank into levels.
  always_comb begin
    levels_d      = levels_q;
    frame_valid_d = 1'b0;
    if (commit_q) begin
      frame_valid_d = 1'b1;
      for (int k = 0; k < BINS; k++) begin
`ifdef SPECTRUM_PEAK_HOLD_EN
        levels_d[k] = peak_next(levels_q[k], bank_q[k]);
`else
        levels_d[k] = bank_q[k];
`endif
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idx_q         <= IDX_SAT;
      bank_q        <= '0;
      commit_q      <= 1'b0;
      levels_q      <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      idx_q         <= idx_d;
      bank_q        <= bank_d;
      commit_q      <= commit_d;
      levels_q      <= levels_d;
      frame_valid_q <= frame_valid_d;
    end
  end

  assign levels      = levels_q;
  assign frame_valid = frame_valid_q;

endmodule

// File: tb/tb_spectrum_bins.sv
// tb_spectrum_bins: directed checks of spectrum_bins at
// default parameters (peak hold follows SPECTRUM_PEAK_HOLD_EN).
module tb_spectrum_bins;

  localparam logic [63:0] RAMP = 64'h31_24_19_10_09_04_01_00;
  localparam logic [63:0] REV  = 64'h00_01_04_09_10_19_24_31;
  localparam logic [63:0] SATV = 64'h31_24_19_10_FF_04_01_00;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               in_valid;
  logic               in_sync;
  logic signed [11:0] in_real;
  logic signed [11:0] in_imag;
  logic [63:0]        levels;
  logic               frame_valid;

  int n_cmp = 0;
  int n_bad = 0;
  int fv_cnt = 0;
  int fv0;
  logic [63:0] exp_lv;
  int fr_re[8];
  int fr_im[8];

  spectrum_bins dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_sync     (in_sync),
    .in_real     (in_real),
    .in_imag     (in_imag),
    .levels      (levels),
    .frame_valid (frame_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (frame_valid === 1'b1) fv_cnt++;

  function automatic logic [63:0] model(
    input logic [63:0] old_v,
    input logic [63:0] new_v
  );
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) begin
`ifdef SPECTRUM_PEAK_HOLD_EN
      begin
        int o, n, d;
        o = {24'd0, old_v[k*8+:8]};
        n = {24'd0, new_v[k*8+:8]};
        d = o - 16;
        if (d < 0) d = 0;
        if (n >= o) r[k*8+:8] = new_v[k*8+:8];
        else if (n > d) r[k*8+:8] = new_v[k*8+:8];
        else r[k*8+:8] = d[7:0];
      end
`else
      r[k*8+:8] = new_v[k*8+:8];
`endif
    end
    return r;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic s, input int re, input int im);
    in_valid = 1'b1;
    in_sync  = s;
    in_real  = re[11:0];
    in_imag  = im[11:0];
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sync  = 1'b0;
  endtask

  task automatic set_ramp();
    for (int k = 0; k < 8; k++) begin
      fr_re[k] = 8 * k;
      fr_im[k] = 0;
    end
  endtask

  task automatic set_rev();
    for (int k = 0; k < 8; k++) begin
      fr_re[k] = 8 * (7 - k);
      fr_im[k] = 0;
    end
  endtask

  task automatic send_frame(input int gap);
    for (int k = 0; k < 8; k++) begin
      drive(k == 0, fr_re[k], fr_im[k]);
      if (k < 7) idle(gap);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
    exp_lv = '0;
  endtask

  task automatic test_reset();
    in_valid = 1'b0;
    in_sync  = 1'b0;
    in_real  = '0;
    in_imag  = '0;
    do_reset();
    n_cmp++;
    if (levels !== 64'd0) begin
      n_bad++;
      $display("FAIL reset_levels: got %h want %h", levels, 64'd0);
    end
    n_cmp++;
    if (frame_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_fv: got %b want 0", frame_valid);
    end
  endtask

  task automatic test_ramp();
    fv0 = fv_cnt;
    set_ramp();
    send_frame(0);
    idle(2);
    n_cmp++;
    if (frame_valid !== 1'b0 || levels !== 64'd0) begin
      n_bad++;
      $display("FAIL ramp_early: fv %b lv %h want 0 / 0",
               frame_valid, levels);
    end
    idle(1);
    exp_lv = model(exp_lv, RAMP);
    n_cmp++;
    if (frame_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL ramp_fv_t3: got %b want 1", frame_valid);
    end
    n_cmp++;
    if (levels !== exp_lv) begin
      n_bad++;
      $display("FAIL ramp_levels: got %h want %h", levels, exp_lv);
    end
    idle(1);
    n_cmp++;
    if (frame_valid !== 1'b0 || fv_cnt - fv0 !== 1) begin
      n_bad++;
      $display("FAIL ramp_pulse: fv %b pulses %0d want 0 / 1",
               frame_valid, fv_cnt - fv0);
    end
  endtask

  task automatic test_saturate();
    fv0 = fv_cnt;
    set_ramp();
    fr_re[3] = -2048;
    fr_im[3] = -2048;
    send_frame(0);
    idle(4);
    exp_lv = model(exp_lv, SATV);
    n_cmp++;
    if (levels !== exp_lv || fv_cnt - fv0 !== 1) begin
      n_bad++;
      $display("FAIL saturate: lv %h pulses %0d want %h / 1",
               levels, fv_cnt - fv0, exp_lv);
    end
  endtask

  task automatic test_abandon();
    fv0 = fv_cnt;
    for (int k = 0; k < 5; k++) drive(k == 0, 56, 0);
    idle(6);
    n_cmp++;
    if (levels !== exp_lv || fv_cnt != fv0) begin
      n_bad++;
      $display("FAIL abandon_hold: lv %h pulses %0d want %h / 0",
               levels, fv_cnt - fv0, exp_lv);
    end
    set_rev();
    send_frame(0);
    idle(4);
    exp_lv = model(exp_lv, REV);
    n_cmp++;
    if (levels !== exp_lv || fv_cnt - fv0 !== 1) begin
      n_bad++;
      $display("FAIL abandon_next: lv %h pulses %0d want %h / 1",
               levels, fv_cnt - fv0, exp_lv);
    end
  endtask

  task automatic test_reset_mid();
    set_ramp();
    for (int k = 0; k < 5; k++) drive(k == 0, fr_re[k], 0);
    reset_n = 1'b0;
    idle(1);
    reset_n = 1'b1;
    exp_lv = '0;
    n_cmp++;
    if (levels !== 64'd0 || frame_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset: lv %h fv %b want 0 / 0",
               levels, frame_valid);
    end
    fv0 = fv_cnt;
    for (int k = 0; k < 8; k++) drive(1'b0, fr_re[k], 0);
    idle(6);
    n_cmp++;
    if (levels !== 64'd0 || fv_cnt != fv0) begin
      n_bad++;
      $display("FAIL unsynced: lv %h pulses %0d want 0 / 0",
               levels, fv_cnt - fv0);
    end
    send_frame(0);
    idle(4);
    exp_lv = model(exp_lv, RAMP);
    n_cmp++;
    if (levels !== exp_lv || fv_cnt - fv0 !== 1) begin
      n_bad++;
      $display("FAIL resync: lv %h pulses %0d want %h / 1",
               levels, fv_cnt - fv0, exp_lv);
    end
  endtask

  task automatic test_gaps();
    do_reset();
    fv0 = fv_cnt;
    set_ramp();
    send_frame(2);
    idle(4);
    exp_lv = model(exp_lv, RAMP);
    n_cmp++;
    if (levels !== exp_lv || fv_cnt - fv0 !== 1) begin
      n_bad++;
      $display("FAIL gaps: lv %h pulses %0d want %h / 1",
               levels, fv_cnt - fv0, exp_lv);
    end
  endtask

  task automatic test_back_to_back();
    fv0 = fv_cnt;
    set_rev();
    send_frame(0);
    idle(2);
    drive(1'b1, 0, 0);
    exp_lv = model(exp_lv, REV);
    n_cmp++;
    if (levels !== exp_lv || frame_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_first: lv %h fv %b want %h / 1",
               levels, frame_valid, exp_lv);
    end
    for (int k = 1; k < 8; k++) drive(1'b0, 8 * k, 0);
    idle(4);
    exp_lv = model(exp_lv, RAMP);
    n_cmp++;
    if (levels !== exp_lv || fv_cnt - fv0 !== 2) begin
      n_bad++;
      $display("FAIL b2b_second: lv %h pulses %0d want %h / 2",
               levels, fv_cnt - fv0, exp_lv);
    end
  endtask

  task automatic test_peak();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      fr_re[k] = 0;
      fr_im[k] = 0;
    end
    fr_re[0] = 80;
    fr_im[0] = 80;
    send_frame(0);
    idle(4);
    n_cmp++;
    if (levels !== 64'h0000_0000_0000_00C8) begin
      n_bad++;
      $display("FAIL peak_f1: got %h want %h",
               levels, 64'h0000_0000_0000_00C8);
    end
    fr_re[0] = 0;
    fr_im[0] = 0;
    send_frame(0);
    idle(4);
`ifdef SPECTRUM_PEAK_HOLD_EN
    exp_lv = 64'h0000_0000_0000_00B8;
`else
    exp_lv = 64'h0;
`endif
    n_cmp++;
    if (levels !== exp_lv) begin
      n_bad++;
      $display("FAIL peak_f2: got %h want %h", levels, exp_lv);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    test_reset();
    test_ramp();
    test_saturate();
    test_abandon();
    test_reset_mid();
    test_gaps();
    test_back_to_back();
    test_peak();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
